// File: rtl/sq_pattern_sender.sv
// Serial pattern transmitter: loads a WIDTH-bit pattern and shifts it onto ds one bit per step_en.
// Latency: load accept -> first bit valid on ds the next cycle; each bit holds until the next step_en.
// Backpressure: load_ready is high only in IDLE; a load offered while busy is ignored (no buffering).
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   step_en               one-cycle advance strobe, one bit per strobe
//   load_valid/load_data  pattern offer; load_ready accepts it (IDLE only)
//   loop                  retransmit the same pattern continuously (sampled at frame end)
//   abort                 drop the current frame and return to IDLE
//   ds, ds_valid          serial data bit and its qualifier
//   bit_idx               index of the bit on ds (0 = first sent)
//   busy                  sender not idle
//   frame_done            one-cycle pulse after the last bit of a frame is stepped
//   frame_cnt             completed frames, wraps
module sq_pattern_sender #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_en,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             loop,
    input  logic             abort,
    output logic             ds,
    output logic             ds_valid,
    output logic [3:0]       bit_idx,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int          LAST_I   = WIDTH - 1;
    localparam logic [3:0]  LAST_IDX = LAST_I[3:0];
    // With GAP == 0 the GAP state is never entered, so the compare value is irrelevant.
    localparam int          GAP_LAST_I = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [3:0]  GAP_LAST   = GAP_LAST_I[3:0];
    localparam int          OUT_BIT    = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] pat;
    logic [3:0]       gap_cnt;

    logic last_step;
    logic gap_end;

    assign last_step = (state == S_SHIFT) && step_en && (bit_idx == LAST_IDX);
    assign gap_end   = (state == S_GAP) && step_en && (gap_cnt == GAP_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (load_valid) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_step) begin
                    if (GAP > 0) begin
                        state_nxt = S_GAP;
                    end else if (loop) begin
                        state_nxt = S_SHIFT;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    state_nxt = loop ? S_SHIFT : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        load_ready = (state == S_IDLE);
        busy       = (state != S_IDLE);
        ds_valid   = (state == S_SHIFT);
        ds         = (state == S_SHIFT) ? shreg[OUT_BIT] : 1'b0;
    end

    // Datapath: shift register, counters and the frame_done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg      <= '0;
            pat        <= '0;
            bit_idx    <= '0;
            gap_cnt    <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (abort) begin
                // Frame is dropped: not counted, no frame_done even on the last-bit step.
                bit_idx <= '0;
                gap_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (load_valid) begin
                            pat     <= load_data;
                            shreg   <= load_data;
                            bit_idx <= '0;
                        end
                    end
                    S_SHIFT: begin
                        if (step_en) begin
                            if (MSB_FIRST != 0) begin
                                shreg <= {shreg[WIDTH-2:0], 1'b0};
                            end else begin
                                shreg <= {1'b0, shreg[WIDTH-1:1]};
                            end
                            if (bit_idx == LAST_IDX) begin
                                frame_done <= 1'b1;
                                frame_cnt  <= frame_cnt + CNT_W'(1);
                                bit_idx    <= '0;
                                if (GAP > 0) begin
                                    gap_cnt <= '0;
                                end else if (loop) begin
                                    shreg <= pat;
                                end
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                            end
                        end
                    end
                    S_GAP: begin
                        if (step_en) begin
                            gap_cnt <= gap_cnt + 4'd1;
                            if (gap_cnt == GAP_LAST && loop) begin
                                shreg <= pat;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sq_pattern_sender.sv
module tb_sq_pattern_sender;

    logic       clk = 1'b0;
    logic       reset;
    logic       step_en;
    logic       load_valid;
    logic [7:0] load_data;
    logic       loop;
    logic       abort;

    // u_a: defaults (MSB first, no gap)
    logic ds_a, dsv_a, lr_a, busy_a, fd_a;
    logic [3:0] idx_a;
    logic [7:0] fc_a;
    // u_b: LSB first
    logic ds_b, dsv_b, lr_b, busy_b, fd_b;
    logic [3:0] idx_b;
    logic [7:0] fc_b;
    // u_c: GAP=2
    logic ds_c, dsv_c, lr_c, busy_c, fd_c;
    logic [3:0] idx_c;
    logic [7:0] fc_c;
    // u_d: CNT_W=2
    logic ds_d, dsv_d, lr_d, busy_d, fd_d;
    logic [3:0] idx_d;
    logic [1:0] fc_d;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sq_pattern_sender #(.WIDTH(8), .MSB_FIRST(1), .GAP(0), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .step_en(step_en), .load_valid(load_valid),
        .load_data(load_data), .load_ready(lr_a), .loop(loop), .abort(abort),
        .ds(ds_a), .ds_valid(dsv_a), .bit_idx(idx_a), .busy(busy_a),
        .frame_done(fd_a), .frame_cnt(fc_a));

    sq_pattern_sender #(.WIDTH(8), .MSB_FIRST(0), .GAP(0), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .step_en(step_en), .load_valid(load_valid),
        .load_data(load_data), .load_ready(lr_b), .loop(loop), .abort(abort),
        .ds(ds_b), .ds_valid(dsv_b), .bit_idx(idx_b), .busy(busy_b),
        .frame_done(fd_b), .frame_cnt(fc_b));

    sq_pattern_sender #(.WIDTH(8), .MSB_FIRST(1), .GAP(2), .CNT_W(8)) u_c (
        .clk(clk), .reset(reset), .step_en(step_en), .load_valid(load_valid),
        .load_data(load_data), .load_ready(lr_c), .loop(loop), .abort(abort),
        .ds(ds_c), .ds_valid(dsv_c), .bit_idx(idx_c), .busy(busy_c),
        .frame_done(fd_c), .frame_cnt(fc_c));

    sq_pattern_sender #(.WIDTH(8), .MSB_FIRST(1), .GAP(0), .CNT_W(2)) u_d (
        .clk(clk), .reset(reset), .step_en(step_en), .load_valid(load_valid),
        .load_data(load_data), .load_ready(lr_d), .loop(loop), .abort(abort),
        .ds(ds_d), .ds_valid(dsv_d), .bit_idx(idx_d), .busy(busy_d),
        .frame_done(fd_d), .frame_cnt(fc_d));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset      = 1'b1;
        step_en    = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        loop       = 1'b0;
        abort      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input logic [7:0] p);
        load_valid = 1'b1;
        load_data  = p;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic step;
        step_en = 1'b1;
        tick();
        step_en = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        tests++; if (ds_a !== 1'b0) begin fails++; $display("FAIL reset_ds got %b want 0", ds_a); end
        tests++; if (dsv_a !== 1'b0) begin fails++; $display("FAIL reset_ds_valid got %b want 0", dsv_a); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy_a); end
        tests++; if (lr_a !== 1'b1) begin fails++; $display("FAIL reset_load_ready got %b want 1", lr_a); end
        tests++; if (fc_a !== 8'd0) begin fails++; $display("FAIL reset_frame_cnt got %0d want 0", fc_a); end
        tests++; if (idx_a !== 4'd0) begin fails++; $display("FAIL reset_bit_idx got %0d want 0", idx_a); end
        tests++; if (fd_a !== 1'b0) begin fails++; $display("FAIL reset_frame_done got %b want 0", fd_a); end
        step();
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL idle_step_ignored busy got %b want 0", busy_a); end
    endtask

    task automatic test_msb_first;
        logic [7:0] seq;
        seq = 8'b1011_0101;  // expected ds order, left to right
        do_reset();
        load(8'hB5);
        for (int i = 0; i < 8; i++) begin
            tests++; if (ds_a !== seq[7-i]) begin fails++; $display("FAIL msb_ds[%0d] got %b want %b", i, ds_a, seq[7-i]); end
            tests++; if (dsv_a !== 1'b1) begin fails++; $display("FAIL msb_ds_valid[%0d] got %b want 1", i, dsv_a); end
            tests++; if (idx_a !== 4'(i)) begin fails++; $display("FAIL msb_bit_idx[%0d] got %0d want %0d", i, idx_a, i); end
            tests++; if (lr_a !== 1'b0) begin fails++; $display("FAIL msb_load_ready[%0d] got %b want 0", i, lr_a); end
            tests++; if (fd_a !== 1'b0) begin fails++; $display("FAIL msb_early_done[%0d] got %b want 0", i, fd_a); end
            step();
        end
        tests++; if (fd_a !== 1'b1) begin fails++; $display("FAIL msb_frame_done got %b want 1", fd_a); end
        tests++; if (fc_a !== 8'd1) begin fails++; $display("FAIL msb_frame_cnt got %0d want 1", fc_a); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL msb_busy_end got %b want 0", busy_a); end
        tests++; if (lr_a !== 1'b1) begin fails++; $display("FAIL msb_load_ready_end got %b want 1", lr_a); end
        tests++; if (dsv_a !== 1'b0) begin fails++; $display("FAIL msb_ds_valid_end got %b want 0", dsv_a); end
        tick();
        tests++; if (fd_a !== 1'b0) begin fails++; $display("FAIL msb_done_pulse_width got %b want 0", fd_a); end
    endtask

    task automatic test_lsb_first;
        logic [7:0] seq;
        seq = 8'b1010_1101;  // B5 sent bit 0 first
        do_reset();
        load(8'hB5);
        for (int i = 0; i < 8; i++) begin
            tests++; if (ds_b !== seq[7-i]) begin fails++; $display("FAIL lsb_ds[%0d] got %b want %b", i, ds_b, seq[7-i]); end
            tests++; if (idx_b !== 4'(i)) begin fails++; $display("FAIL lsb_bit_idx[%0d] got %0d want %0d", i, idx_b, i); end
            step();
        end
        tests++; if (fd_b !== 1'b1) begin fails++; $display("FAIL lsb_frame_done got %b want 1", fd_b); end
        tests++; if (fc_b !== 8'd1) begin fails++; $display("FAIL lsb_frame_cnt got %0d want 1", fc_b); end
    endtask

    task automatic test_loop_gap;
        logic [19:0] vtab;
        logic [19:0] dtab;
        vtab = 20'b11111111_00_11111111_00;
        dtab = 20'b00001111_00_00001111_00;
        do_reset();
        loop = 1'b1;
        load(8'h0F);
        for (int s = 0; s < 20; s++) begin
            tests++; if (dsv_c !== vtab[19-s]) begin fails++; $display("FAIL gap_ds_valid[%0d] got %b want %b", s, dsv_c, vtab[19-s]); end
            tests++; if (ds_c !== dtab[19-s]) begin fails++; $display("FAIL gap_ds[%0d] got %b want %b", s, ds_c, dtab[19-s]); end
            step();
        end
        tests++; if (fc_c !== 8'd2) begin fails++; $display("FAIL gap_frame_cnt got %0d want 2", fc_c); end
        tests++; if (dsv_c !== 1'b1) begin fails++; $display("FAIL gap_reenter_shift got %b want 1", dsv_c); end
        tests++; if (idx_c !== 4'd0) begin fails++; $display("FAIL gap_bit_idx got %0d want 0", idx_c); end
        loop  = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests++; if (busy_c !== 1'b0) begin fails++; $display("FAIL gap_abort_busy got %b want 0", busy_c); end
    endtask

    task automatic test_load_while_busy;
        logic [7:0] seq;
        seq = 8'b0011_1100;
        do_reset();
        load(8'h3C);
        load_valid = 1'b1;
        load_data  = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            tests++; if (ds_a !== seq[7-i]) begin fails++; $display("FAIL busy_load_ds[%0d] got %b want %b", i, ds_a, seq[7-i]); end
            tests++; if (lr_a !== 1'b0) begin fails++; $display("FAIL busy_load_ready[%0d] got %b want 0", i, lr_a); end
            if (i == 7) load_valid = 1'b0;
            step();
        end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL busy_load_end busy got %b want 0", busy_a); end
        tests++; if (fc_a !== 8'd1) begin fails++; $display("FAIL busy_load_frame_cnt got %0d want 1", fc_a); end
    endtask

    task automatic test_abort_reset;
        logic [7:0] seq;
        seq = 8'b1010_1010;
        do_reset();
        // one full frame so frame_cnt is nonzero
        load(8'hAA);
        for (int i = 0; i < 8; i++) step();
        tests++; if (fc_a !== 8'd1) begin fails++; $display("FAIL abort_pre_cnt got %0d want 1", fc_a); end
        // abort after 3 bits
        load(8'hAA);
        for (int i = 0; i < 3; i++) begin
            tests++; if (ds_a !== seq[7-i]) begin fails++; $display("FAIL abort_ds[%0d] got %b want %b", i, ds_a, seq[7-i]); end
            step();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy_a); end
        tests++; if (dsv_a !== 1'b0) begin fails++; $display("FAIL abort_ds_valid got %b want 0", dsv_a); end
        tests++; if (idx_a !== 4'd0) begin fails++; $display("FAIL abort_bit_idx got %0d want 0", idx_a); end
        tests++; if (fc_a !== 8'd1) begin fails++; $display("FAIL abort_frame_cnt got %0d want 1", fc_a); end
        tests++; if (fd_a !== 1'b0) begin fails++; $display("FAIL abort_frame_done got %b want 0", fd_a); end
        // abort coincident with the last-bit step: frame not counted
        load(8'hAA);
        for (int i = 0; i < 7; i++) step();
        tests++; if (idx_a !== 4'd7) begin fails++; $display("FAIL abort_last_idx got %0d want 7", idx_a); end
        step_en = 1'b1;
        abort   = 1'b1;
        tick();
        step_en = 1'b0;
        abort   = 1'b0;
        tests++; if (fd_a !== 1'b0) begin fails++; $display("FAIL abort_last_done got %b want 0", fd_a); end
        tests++; if (fc_a !== 8'd1) begin fails++; $display("FAIL abort_last_cnt got %0d want 1", fc_a); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL abort_last_busy got %b want 0", busy_a); end
        // reset mid-frame
        load(8'hAA);
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (fc_a !== 8'd0) begin fails++; $display("FAIL midreset_frame_cnt got %0d want 0", fc_a); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL midreset_busy got %b want 0", busy_a); end
        tests++; if (ds_a !== 1'b0) begin fails++; $display("FAIL midreset_ds got %b want 0", ds_a); end
        tests++; if (idx_a !== 4'd0) begin fails++; $display("FAIL midreset_bit_idx got %0d want 0", idx_a); end
        tests++; if (lr_a !== 1'b1) begin fails++; $display("FAIL midreset_load_ready got %b want 1", lr_a); end
    endtask

    task automatic test_cnt_wrap;
        logic [7:0] seq;
        logic [1:0] fctab [5];
        seq   = 8'b1001_0110;
        fctab = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        loop = 1'b1;
        load(8'h96);
        step_en = 1'b1;  // held high: one bit per cycle
        for (int f = 0; f < 5; f++) begin
            for (int b = 0; b < 8; b++) begin
                tests++; if (ds_d !== seq[7-b]) begin fails++; $display("FAIL wrap_ds[%0d][%0d] got %b want %b", f, b, ds_d, seq[7-b]); end
                tests++; if (idx_d !== 4'(b)) begin fails++; $display("FAIL wrap_bit_idx[%0d][%0d] got %0d want %0d", f, b, idx_d, b); end
                tick();
            end
            tests++; if (fc_d !== fctab[f]) begin fails++; $display("FAIL wrap_frame_cnt[%0d] got %0d want %0d", f, fc_d, fctab[f]); end
            tests++; if (fd_d !== 1'b1) begin fails++; $display("FAIL wrap_frame_done[%0d] got %b want 1", f, fd_d); end
        end
        step_en = 1'b0;
        loop    = 1'b0;
        abort   = 1'b1;
        tick();
        abort   = 1'b0;
        tests++; if (busy_d !== 1'b0) begin fails++; $display("FAIL wrap_abort_busy got %b want 0", busy_d); end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_loop_gap();
        test_load_while_busy();
        test_abort_reset();
        test_cnt_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
